io_serial_receiver: RTL and testbench



---
 rtl/io_serial_receiver_pkg.sv | 14 +
 rtl/io_serial_receiver_if.sv | 23 ++
 rtl/io_serial_rx_fifo.sv | 48 ++++
 rtl/io_serial_receiver.sv | 106 ++++++++++
 tb/tb_io_serial_receiver.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/io_serial_receiver_pkg.sv
// Shared types for the IO unit serial receive path.
//   SERIAL_RX_DATA_WIDTH / SerialRxDataPath : one received character
//   SerialRxState                           : receiver FSM states
//   SerialRxFifoPtr                         : FIFO pointer for the default depth
//                                             (extra MSB distinguishes full/empty)
package io_serial_receiver_pkg;
  localparam int SERIAL_RX_DATA_WIDTH = 8;
  typedef logic [SERIAL_RX_DATA_WIDTH-1:0] SerialRxDataPath;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} SerialRxState;

  localparam int SERIAL_RX_FIFO_DEPTH = 4;
  typedef logic [$clog2(SERIAL_RX_FIFO_DEPTH):0] SerialRxFifoPtr;
endpackage

// File: rtl/io_serial_receiver_if.sv
// Processor-side bus of the serial receiver.
//   master : the receiver (drives data/valid/flags, takes read/clear strobes)
//   slave  : the IO unit register block that pops bytes and clears errors
interface io_serial_receiver_if;
  import io_serial_receiver_pkg::*;

  logic            rxValid;
  SerialRxDataPath rxData;
  logic            rxRead;
  logic            rxOverrun;
  logic            rxFramingError;
  logic            errClear;

  modport master (
    output rxValid, rxData, rxOverrun, rxFramingError,
    input  rxRead, errClear
  );

  modport slave (
    input  rxValid, rxData, rxOverrun, rxFramingError,
    output rxRead, errClear
  );
endinterface

// File: rtl/io_serial_rx_fifo.sv
// First-word-fall-through receive FIFO.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wrData: write one byte (ignored by the caller's choice when full)
//   pop        : remove head byte; ignored when empty
//   rdData     : head byte, forced to 0 while empty
//   full/empty : occupancy status
module io_serial_rx_fifo
  import io_serial_receiver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  SerialRxDataPath wrData,
  input  logic            pop,
  output SerialRxDataPath rdData,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit: equal pointers mean empty, MSB-only difference means full.
  logic [AW:0]     wrPtr, rdPtr;
  SerialRxDataPath mem [DEPTH];
  logic            doPush, doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign doPush = push && (!full || doPop);
  assign rdData = empty ? '0 : mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
  end
endmodule

// File: rtl/io_serial_receiver.sv
// 8N1 serial receiver with FIFO and sticky error flags.
//   clk, rst_n : core clock, async active-low reset
//   serialIn   : asynchronous serial line, idles high
//   rx         : processor-side bus (valid/data/read, overrun/framing flags, clear)
// Bits are timed by counting CLKS_PER_BIT core clocks; samples land at bit centres.
module io_serial_receiver
  import io_serial_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic serialIn,
  io_serial_receiver_if.master rx
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  logic            lineMeta, lineS;
  SerialRxState    state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitIdx;
  SerialRxDataPath shReg;
  logic            stopSample, pushByte, frameBad;
  logic            fifoFull, fifoEmpty, dropByte;
  logic            overrun, framingError;

  // Two-flop synchronizer, reset to the idle (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lineMeta <= 1'b1;
      lineS    <= 1'b1;
    end else begin
      lineMeta <= serialIn;
      lineS    <= lineMeta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bitIdx <= '0;
      shReg  <= '0;
    end else begin
      case (state)
        IDLE: if (!lineS) begin
          // Half a bit to reach the centre of the start bit.
          cnt   <= CW'(CLKS_PER_BIT/2 - 1);
          state <= START;
        end
        START: if (cnt != '0) cnt <= cnt - CW'(1);
          else if (lineS) state <= IDLE;  // too short to be a start bit
          else begin
            cnt    <= CW'(CLKS_PER_BIT - 1);
            bitIdx <= '0;
            state  <= DATA;
          end
        DATA: if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            // LSB arrives first; shifting right in from the top leaves it at bit 0.
            shReg  <= {lineS, shReg[SERIAL_RX_DATA_WIDTH-1:1]};
            cnt    <= CW'(CLKS_PER_BIT - 1);
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) state <= STOP;
          end
        STOP: if (cnt != '0) cnt <= cnt - CW'(1);
          else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stopSample = (state == STOP) && (cnt == '0);
  assign pushByte   = stopSample && lineS;
  assign frameBad   = stopSample && !lineS;
  assign dropByte   = pushByte && fifoFull && !(rx.rxRead && !fifoEmpty);

  io_serial_rx_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (pushByte),
    .wrData (shReg),
    .pop    (rx.rxRead),
    .rdData (rx.rxData),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Sticky flags: a new event in the clear cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun      <= 1'b0;
      framingError <= 1'b0;
    end else begin
      if (dropByte)         overrun <= 1'b1;
      else if (rx.errClear) overrun <= 1'b0;
      if (frameBad)         framingError <= 1'b1;
      else if (rx.errClear) framingError <= 1'b0;
    end
  end

  assign rx.rxValid        = !fifoEmpty;
  assign rx.rxOverrun      = overrun;
  assign rx.rxFramingError = framingError;
endmodule

// File: tb/tb_io_serial_receiver.sv
module tb_io_serial_receiver;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic serialIn = 1'b1;
  always #5 clk = ~clk;

  io_serial_receiver_if rxIf();

  io_serial_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .serialIn (serialIn),
    .rx       (rxIf)
  );

  int total = 0;
  int bad   = 0;

  // Reference: a byte queue plus two flags, updated once per completed frame.
  byte unsigned mq[$];
  bit mOvr = 1'b0;
  bit mFrm = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one 8N1 frame starting at a negedge; returns at the end of the stop bit.
  task automatic sendFrame(input logic [7:0] b, input bit stopOk);
    logic [9:0] bits;
    bits = {stopOk, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serialIn = bits[i];
      repeat (CPB) @(negedge clk);
    end
    serialIn = 1'b1;
  endtask

  task automatic modelFrame(input logic [7:0] b, input bit stopOk);
    if (!stopOk) mFrm = 1'b1;
    else if (mq.size() == DEPTH) mOvr = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic checkState(input string tag);
    chk({tag, "_vld"}, rxIf.rxValid, mq.size() != 0);
    if (mq.size() != 0) chk({tag, "_data"}, rxIf.rxData, mq[0]);
    chk({tag, "_ovr"}, rxIf.rxOverrun, mOvr);
    chk({tag, "_frm"}, rxIf.rxFramingError, mFrm);
  endtask

  task automatic popByte(input string tag);
    chk({tag, "_vld"}, rxIf.rxValid, mq.size() != 0);
    if (mq.size() != 0) chk({tag, "_data"}, rxIf.rxData, mq[0]);
    rxIf.rxRead = 1'b1;
    @(negedge clk);
    rxIf.rxRead = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clrErr();
    rxIf.errClear = 1'b1;
    @(negedge clk);
    rxIf.errClear = 1'b0;
    mOvr = 1'b0;
    mFrm = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    bit ok;
    rxIf.rxRead   = 1'b0;
    rxIf.errClear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vld", rxIf.rxValid, 0);
    chk("rst_data", rxIf.rxData, 0);
    chk("rst_ovr", rxIf.rxOverrun, 0);
    chk("rst_frm", rxIf.rxFramingError, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame and start-edge-to-valid latency.
    n = 0;
    fork
      sendFrame(8'hA5, 1'b1);
      while (n < 200 && !rxIf.rxValid) begin
        @(negedge clk);
        n++;
      end
    join
    chk("lat_155pm1", (n >= 154 && n <= 156), 1);
    modelFrame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    checkState("a5");
    popByte("a5pop");
    checkState("a5empty");

    // Read while empty is ignored.
    popByte("emptyRd");
    checkState("emptyRd2");

    // Short low glitch on an idle line.
    serialIn = 1'b0;
    repeat (4) @(negedge clk);
    serialIn = 1'b1;
    repeat (40) @(negedge clk);
    checkState("glitch");

    // Framing error, then clear.
    sendFrame(8'h3C, 1'b0);
    modelFrame(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    checkState("frm");
    clrErr();
    chk("frmClr", rxIf.rxFramingError, 0);

    // Overrun on the fifth queued byte.
    for (int i = 1; i <= 5; i++) begin
      sendFrame(8'(i), 1'b1);
      modelFrame(8'(i), 1'b1);
      repeat (2) @(negedge clk);
    end
    checkState("ovr");
    for (int i = 0; i < 4; i++) popByte("ovrPop");
    checkState("ovrDrained");
    clrErr();

    // Full FIFO, pop exactly on the push cycle of 0x14: no overrun.
    for (int i = 0; i < 4; i++) begin
      sendFrame(8'h10 + 8'(i), 1'b1);
      modelFrame(8'h10 + 8'(i), 1'b1);
      repeat (2) @(negedge clk);
    end
    fork
      sendFrame(8'h14, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rxIf.rxRead = 1'b1;
        @(negedge clk);
        rxIf.rxRead = 1'b0;
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'h14);
    repeat (4) @(negedge clk);
    checkState("simul");
    for (int i = 0; i < 4; i++) popByte("simulPop");
    checkState("simulEmpty");

    // Reset mid-frame with bytes queued and a flag set.
    sendFrame(8'h21, 1'b1); modelFrame(8'h21, 1'b1);
    sendFrame(8'h22, 1'b1); modelFrame(8'h22, 1'b1);
    sendFrame(8'h99, 1'b0); modelFrame(8'h99, 1'b0);
    repeat (20) @(negedge clk);
    checkState("preRst");
    fork
      sendFrame(8'h77, 1'b1);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midRst_vld", rxIf.rxValid, 0);
        chk("midRst_ovr", rxIf.rxOverrun, 0);
        chk("midRst_frm", rxIf.rxFramingError, 0);
      end
    join
    mq.delete();
    mOvr = 1'b0;
    mFrm = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    sendFrame(8'h5A, 1'b1);
    modelFrame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    checkState("postRst");
    popByte("postRstPop");

    // Randomized frames, stop errors, reads and clears.
    for (int it = 0; it < 16; it++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      sendFrame(b, ok);
      modelFrame(b, ok);
      repeat (20) @(negedge clk);
      checkState("rnd");
      n = $urandom_range(0, 2);
      for (int r = 0; r < n; r++) popByte("rndPop");
      if ($urandom_range(0, 3) == 0) clrErr();
      checkState("rndPost");
    end
    while (mq.size() != 0) popByte("drain");
    checkState("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
